// File: rtl/icache_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : icache_responder_if
//  Purpose  : Fetch-side ibus and memory-side cbus signal bundle for the
//             instruction cache responder.
//  Revision : 1.0 - initial release
// ============================================================================
interface icache_responder_if;
  // ibus: fetch stage initiator
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  // cbus: memory side
  logic        creq_valid;
  logic        creq_is_write;
  logic [2:0]  creq_size;
  logic [63:0] creq_addr;
  logic [7:0]  creq_strobe;
  logic [63:0] creq_data;
  logic [7:0]  creq_len;
  logic [1:0]  creq_burst;
  logic        cresp_ready;
  logic        cresp_last;
  logic [63:0] cresp_data;

  modport slave (
    input  ireq_valid, ireq_addr, cresp_ready, cresp_last, cresp_data,
    output iresp_addr_ok, iresp_data_ok, iresp_data,
           creq_valid, creq_is_write, creq_size, creq_addr, creq_strobe,
           creq_data, creq_len, creq_burst
  );

  modport master (
    output ireq_valid, ireq_addr, cresp_ready, cresp_last, cresp_data,
    input  iresp_addr_ok, iresp_data_ok, iresp_data,
           creq_valid, creq_is_write, creq_size, creq_addr, creq_strobe,
           creq_data, creq_len, creq_burst
  );
endinterface
`default_nettype wire

// File: rtl/icache_responder.sv
`default_nettype none
// ============================================================================
//  Module   : icache_responder
//  Purpose  : Direct-mapped register-based instruction cache with zero-latency
//             hits, burst line refill over cbus and whole-cache flush.
//  Revision : 1.0 - initial release
// ============================================================================
module icache_responder #(
  parameter int LINES = 64,
  parameter int BEATS = 4
) (
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic            flush,
  icache_responder_if.slave    bus
);

  localparam int c_OFS  = $clog2(8 * BEATS);
  localparam int c_IDX  = $clog2(LINES);
  localparam int c_TAGW = 64 - c_OFS - c_IDX;
  localparam int c_CNTW = $clog2(BEATS);

  localparam logic [2:0] c_MSIZE8     = 3'd3;
  localparam logic [7:0] c_MLEN       = 8'(BEATS - 1);
  localparam logic [1:0] c_BURST_INCR = 2'b01;

  localparam logic [1:0] c_S_IDLE      = 2'd0;
  localparam logic [1:0] c_S_REFILL    = 2'd1;
  localparam logic [1:0] c_S_FLUSHWAIT = 2'd2;

  logic [1:0]          r_state;
  logic [LINES-1:0]    r_valid;
  logic [c_TAGW-1:0]   r_tag  [LINES];
  logic [63:0]         r_data [LINES][BEATS];
  logic [63-c_OFS:0]   r_line;
  logic [c_CNTW-1:0]   r_cnt;
  logic                r_flush_pend;

  logic [c_IDX-1:0]    w_idx;
  logic [c_TAGW-1:0]   w_tag;
  logic [c_CNTW-1:0]   w_beat;
  logic [63:0]         w_word;
  logic                w_hit;
  logic                w_serve;
  logic [c_IDX-1:0]    w_fidx;
  logic [c_TAGW-1:0]   w_ftag;
  logic                w_beat_done;
  logic                w_last;
  logic                w_unused;

  assign w_idx  = bus.ireq_addr[c_OFS+c_IDX-1:c_OFS];
  assign w_tag  = bus.ireq_addr[63:c_OFS+c_IDX];
  assign w_beat = bus.ireq_addr[c_OFS-1:3];
  assign w_word = r_data[w_idx][w_beat];
  assign w_hit  = bus.ireq_valid && r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // Lookups are only answered from IDLE; reset forces the response low.
  assign w_serve = (r_state == c_S_IDLE) && !reset && w_hit;

  assign bus.iresp_addr_ok = w_serve;
  assign bus.iresp_data_ok = w_serve;
  assign bus.iresp_data    = bus.ireq_addr[2] ? w_word[63:32] : w_word[31:0];

  assign w_fidx      = r_line[c_IDX-1:0];
  assign w_ftag      = r_line[63-c_OFS:c_IDX];
  assign w_beat_done = (r_state == c_S_REFILL) && bus.cresp_ready;
  assign w_last      = w_beat_done && bus.cresp_last;

  assign bus.creq_valid    = (r_state == c_S_REFILL);
  assign bus.creq_is_write = 1'b0;
  assign bus.creq_size     = c_MSIZE8;
  assign bus.creq_addr     = {r_line, {c_OFS{1'b0}}};
  assign bus.creq_strobe   = 8'h00;
  assign bus.creq_data     = 64'h0;
  assign bus.creq_len      = c_MLEN;
  assign bus.creq_burst    = c_BURST_INCR;

  assign w_unused = &{1'b0, bus.ireq_addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= c_S_IDLE;
      r_valid      <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (flush) begin
            r_valid <= '0;
          end
          if (bus.ireq_valid && !w_hit) begin
            r_line       <= bus.ireq_addr[63:c_OFS];
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_state      <= c_S_REFILL;
          end
        end
        c_S_REFILL: begin
          if (w_beat_done) begin
            r_cnt <= r_cnt + c_CNTW'(1);
          end
          if (w_last) begin
            // A flush seen during the burst wipes the freshly filled line too.
            if (r_flush_pend) begin
              r_valid <= '0;
              r_state <= c_S_IDLE;
            end else begin
              r_valid[w_fidx] <= 1'b1;
              r_state         <= flush ? c_S_FLUSHWAIT : c_S_IDLE;
            end
            r_flush_pend <= 1'b0;
          end else if (flush) begin
            r_flush_pend <= 1'b1;
          end
        end
        c_S_FLUSHWAIT: begin
          r_valid <= '0;
          r_state <= c_S_IDLE;
        end
        default: begin
          r_state <= c_S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_beat_done) begin
      r_data[w_fidx][r_cnt] <= bus.cresp_data;
    end
    if (w_last) begin
      r_tag[w_fidx] <= w_ftag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_responder
//  Purpose  : Directed and randomized self-checking bench for icache_responder
//             against a transaction-level cache model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icache_responder;
  localparam int LINES = 64;
  localparam int BEATS = 4;
  localparam int OFS   = 5;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  icache_responder_if bus ();

  icache_responder #(.LINES(LINES), .BEATS(BEATS)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: which memory line each cache slot holds, plus refill progress.
  bit          m_v        [LINES];
  logic [63:0] m_tagline  [LINES];
  bit          m_busy, m_fw, m_pend, m_done, m_init;
  logic [63:0] m_fill_line;
  int          m_beat;
  int          p_ready;
  logic [63:0] pool [5];

  function automatic logic [63:0] memword(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_1234, a[31:0] + 32'h0000_1357};
  endfunction

  function automatic int idx_of(input logic [63:0] a);
    return int'((a >> OFS) % LINES);
  endfunction

  function automatic bit exp_hit();
    int i;
    if (reset || m_busy || m_fw || !bus.ireq_valid) return 1'b0;
    i = idx_of(bus.ireq_addr);
    return m_v[i] && (m_tagline[i] == (bus.ireq_addr >> OFS));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < LINES; i++) m_v[i] = 1'b0;
  endtask

  task automatic model_update();
    bit h;
    int i;
    if (reset) begin
      clear_all();
      m_busy = 0; m_fw = 0; m_pend = 0; m_done = 1;
      return;
    end
    h = exp_hit();
    m_done = !(bus.ireq_valid && !h);
    if (m_fw) begin
      clear_all();
      m_fw = 0;
    end else if (!m_busy) begin
      if (bus.ireq_valid && !h) begin
        m_busy = 1; m_fill_line = bus.ireq_addr >> OFS; m_beat = 0; m_pend = 0;
      end
      if (flush) clear_all();
    end else begin
      if (bus.cresp_ready && bus.cresp_last) begin
        m_busy = 0;
        if (m_pend) clear_all();
        else begin
          i = int'(m_fill_line % LINES);
          m_v[i] = 1'b1;
          m_tagline[i] = m_fill_line;
          if (flush) m_fw = 1;
        end
        m_pend = 0;
      end else begin
        if (bus.cresp_ready) m_beat++;
        if (flush) m_pend = 1;
      end
    end
  endtask

  task automatic drive(input bit r, input bit f, input bit v, input logic [63:0] a);
    reset = r;
    flush = f;
    bus.ireq_valid  = v;
    bus.ireq_addr   = a;
    bus.cresp_ready = m_busy && ($urandom_range(0, 99) < p_ready);
    bus.cresp_last  = bus.cresp_ready && (m_beat == BEATS - 1);
    bus.cresp_data  = bus.cresp_ready ? memword((m_fill_line << OFS) + 64'(m_beat * 8))
                                      : {$urandom, $urandom};
  endtask

  task automatic cyc(input bit r, input bit f, input bit v, input logic [63:0] a);
    @(posedge clk);
    model_update();
    #1;
    drive(r, f, v, a);
    #1;
  endtask

  task automatic wait_hit(input logic [63:0] a, output int n);
    n = 0;
    do begin
      cyc(0, 0, 1, a);
      n++;
    end while (!bus.iresp_data_ok && n < 40);
    if (!bus.iresp_data_ok) chk("hit_timeout", {63'd0, bus.iresp_data_ok}, 64'd1);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    bit          h;
    logic [63:0] w;
    if (m_init && !reset) begin
      h = exp_hit();
      chk("data_ok",    {63'd0, bus.iresp_data_ok}, {63'd0, h});
      chk("addr_ok",    {63'd0, bus.iresp_addr_ok}, {63'd0, h});
      chk("creq_valid", {63'd0, bus.creq_valid},    {63'd0, m_busy});
      if (h) begin
        w = memword(bus.ireq_addr & ~64'h7);
        chk("hit_data", {32'd0, bus.iresp_data}, {32'd0, bus.ireq_addr[2] ? w[63:32] : w[31:0]});
      end
      if (m_busy) begin
        chk("creq_addr",  bus.creq_addr, m_fill_line << OFS);
        chk("creq_len",   {56'd0, bus.creq_len}, 64'd3);
        chk("creq_size",  {61'd0, bus.creq_size}, 64'd3);
        chk("creq_burst", {62'd0, bus.creq_burst}, 64'd1);
        chk("creq_wr",    {63'd0, bus.creq_is_write}, 64'd0);
        chk("creq_strb",  {56'd0, bus.creq_strobe}, 64'd0);
      end
    end
  end

  initial begin
    int n;
    logic [63:0] ra;
    bit rv;
    pool[0] = 64'h0000_0000_8000_0000;
    pool[1] = 64'h0000_0000_8000_0800;
    pool[2] = 64'h0000_0000_8000_1000;
    pool[3] = 64'h0000_0000_8000_0020;
    pool[4] = 64'hFFFF_0000_1234_5660;
    reset = 1; flush = 0; p_ready = 100;
    bus.ireq_valid = 0; bus.ireq_addr = '0;
    bus.cresp_ready = 0; bus.cresp_last = 0; bus.cresp_data = '0;
    m_busy = 0; m_fw = 0; m_pend = 0; m_done = 1; m_init = 0; m_beat = 0; m_fill_line = '0;

    cyc(1, 0, 0, 64'h0);
    m_init = 1;
    cyc(1, 0, 0, 64'h0);
    cyc(0, 0, 0, 64'h0);
    chk("rst_creq_valid", {63'd0, bus.creq_valid},    64'd0);
    chk("rst_data_ok",    {63'd0, bus.iresp_data_ok}, 64'd0);
    chk("rst_addr_ok",    {63'd0, bus.iresp_addr_ok}, 64'd0);

    // First fill of 0x8000_0000
    cyc(0, 0, 1, 64'h8000_0000);
    chk("miss_data_ok", {63'd0, bus.iresp_data_ok}, 64'd0);
    cyc(0, 0, 1, 64'h8000_0000);
    chk("refill_valid", {63'd0, bus.creq_valid}, 64'd1);
    chk("refill_addr",  bus.creq_addr, 64'h8000_0000);
    wait_hit(64'h8000_0000, n);
    chk("miss_latency", 64'(n), 64'd4);
    chk("fill_lo_b0",   {32'd0, bus.iresp_data}, 64'h8000_1357);

    cyc(0, 0, 1, 64'h8000_0004);
    chk("hit_hi_b0_ok", {63'd0, bus.iresp_data_ok}, 64'd1);
    chk("hit_hi_b0",    {32'd0, bus.iresp_data}, 64'hDA5A_1234);
    cyc(0, 0, 1, 64'h8000_001C);
    chk("hit_hi_b3_ok", {63'd0, bus.iresp_data_ok}, 64'd1);
    chk("hit_hi_b3",    {32'd0, bus.iresp_data}, 64'hDA5A_122C);

    // Conflict on index 0
    cyc(0, 0, 1, 64'h8000_0800);
    chk("conflict_miss", {63'd0, bus.iresp_data_ok}, 64'd0);
    wait_hit(64'h8000_0800, n);
    chk("conflict_lat", 64'(n), 64'd5);
    cyc(0, 0, 1, 64'h8000_0000);
    chk("evicted_miss", {63'd0, bus.iresp_data_ok}, 64'd0);
    wait_hit(64'h8000_0000, n);

    // Flush while idle
    cyc(0, 1, 0, 64'h0);
    cyc(0, 0, 1, 64'h8000_0000);
    chk("flush_idle_miss", {63'd0, bus.iresp_data_ok}, 64'd0);
    wait_hit(64'h8000_0000, n);

    // Flush during beat 1 of a refill: full burst, re-miss, second refill
    cyc(0, 0, 1, 64'h8000_0040);
    cyc(0, 0, 1, 64'h8000_0040);
    cyc(0, 1, 1, 64'h8000_0040);
    wait_hit(64'h8000_0040, n);
    chk("flush_refill_lat", 64'(n), 64'd8);

    // Reset during beat 2 of a refill
    cyc(0, 0, 1, 64'h8000_0080);
    cyc(0, 0, 1, 64'h8000_0080);
    cyc(0, 0, 1, 64'h8000_0080);
    cyc(1, 0, 1, 64'h8000_0080);
    cyc(0, 0, 0, 64'h8000_0080);
    chk("rst_mid_creq_valid", {63'd0, bus.creq_valid}, 64'd0);
    cyc(0, 0, 1, 64'h8000_0080);
    chk("rst_mid_miss", {63'd0, bus.iresp_data_ok}, 64'd0);
    wait_hit(64'h8000_0080, n);
    chk("rst_mid_lat", 64'(n), 64'd5);

    // Randomized traffic with back-pressure, flushes and occasional reset
    p_ready = 70;
    rv = 0; ra = '0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      model_update();
      #1;
      if (m_done) begin
        rv = ($urandom_range(0, 9) != 0);
        ra = pool[$urandom_range(0, 4)] + 64'($urandom_range(0, 31));
      end
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0, rv, ra);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Instruction-side responder that sits between the fetch stage's ibus initiator and the memory-side cbus.
- Serves ibus fetch requests from a direct-mapped instruction cache held in registers.
- On a miss, performs a burst line refill over cbus.
- Provides a whole-cache invalidate for fence.i.

Parameters:
- LINES, 64: number of cache lines; must be a power of two.
- BEATS, 4: 64-bit beats per line; must be a power of two; line size is 8*BEATS bytes (default 32).

Ports:
- clk  input  1  system clock.
- reset  input  1  reset; synchronous, active-high.
- ireq  input  ibus_req_t  fetch request {valid, addr}; addr held stable while valid && !data_ok.
- iresp  output  ibus_resp_t  {addr_ok, data_ok, data[31:0]}.
- creq  output  cbus_req_t  refill request {valid, is_write, size, addr, strobe, data, len, burst}.
- cresp  input  cbus_resp_t  {ready, last, data[63:0]}.
- flush  input  1  single-cycle pulse; invalidates all lines.

Behaviour:
- Address split, with OFS = log2(8*BEATS) and IDX = log2(LINES):
  - addr[1:0] is ignored.
  - addr[2] selects the 32-bit half of a beat.
  - addr[OFS-1:3] is the beat index.
  - addr[OFS+IDX-1:OFS] is the line index.
  - addr[63:OFS+IDX] is the tag.
- Storage:
  - valid[LINES], tag[LINES], data[LINES][BEATS] x 64-bit, all registers.
  - Reads are combinational.
- States: IDLE, REFILL, FLUSHWAIT. Reset puts the block in IDLE, clears all valid bits, and drives creq.valid=0, iresp.addr_ok=0, iresp.data_ok=0. Data and tag arrays are not reset.
- IDLE:
  - On hit (ireq.valid && valid[idx] && tag match): addr_ok=1 and data_ok=1 in the same cycle; data = the selected 32-bit half (addr[2]=0 gives the low half). Zero-latency hit.
  - On miss (ireq.valid and not a hit): data_ok=0; latch the line-aligned address (addr[63:OFS], low bits 0); next state REFILL.
  - When ireq.valid=0: data_ok=0 and addr_ok=0.
- REFILL:
  - creq drives: valid=1, is_write=0, size=MSIZE8, len=BEATS-1 encoding (MLEN for BEATS), burst=AXI_BURST_INCR, strobe=0, addr = latched aligned address.
  - A beat counter starts at 0. On each cresp.ready, data[idx][cnt] is written with cresp.data and cnt increments.
  - On cresp.ready && cresp.last: write the final beat, set valid[idx]=1 and tag[idx]=latched tag, drop creq.valid the next cycle, and return to IDLE.
  - iresp.data_ok=0 throughout REFILL.
  - The held request hits in IDLE on the cycle after the last beat: miss latency = burst time + 1 cycle.
- Flush:
  - In IDLE: all valid bits clear at the clock edge. A hit lookup in that same cycle still uses pre-flush state and responds.
  - In REFILL: flush is recorded in a pending bit. The refill completes and writes its line. At the last beat, all valid bits (including the just-filled line) are cleared instead of setting valid, and the state goes to IDLE, where the held request re-misses.
  - FLUSHWAIT is used only if flush arrives on the last-beat cycle. It performs the clear in one cycle, then goes to IDLE.
- Reset mid-refill: return to IDLE immediately, drop creq.valid, clear all valid bits. The responder does not wait for cresp.last; the memory side is reset by the same signal.
- ireq.addr change during REFILL is a protocol violation. The line fetched is the originally latched one.
- A request whose tag matches but whose valid bit is 0 is a miss.
- Beat counter width is log2(BEATS); it wraps to 0 after the last beat.

Test Plan:
- Reset, then ireq.valid=1, addr=0x8000_0000 -> data_ok=0, creq.valid=1, creq.addr=0x8000_0000, 4 beats; data_ok=1 one cycle after last beat, data = low half of beat 0.
- After that fill, addr=0x8000_0004 then 0x8000_001C -> each data_ok=1 in the same cycle (hit), data = high half of beat 0, then high half of beat 3.
- Conflict: addr=0x8000_0000 filled, then addr=0x8000_0800 (same index, LINES=64) -> miss and refill; then addr=0x8000_0000 misses again.
- Flush in IDLE after filling 0x8000_0000 -> next request to 0x8000_0000 misses and refills.
- Flush pulsed mid-REFILL (beat 1 of 4) -> burst completes all 4 beats; held request re-misses and a second refill of the same address is issued.
- Reset asserted during beat 2 of a refill -> next cycle creq.valid=0 and state IDLE; a subsequent request to the same address misses.
